// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset control FSM: fetch/decode/exec/mem/wb sequencing plus control decode.
// Latency: 2 to 5 cycles per instruction depending on class; outputs are state_q/ir_q decode only.
// Backpressure: none; the FSM advances every cycle and reset aborts any in-flight instruction.
module mc_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic [2:0]  MemtoReg,
  output logic [2:0]  ALUOp,
  output logic [2:0]  ALUSrc,
  output logic [2:0]  RegDst,
  output logic [2:0]  DMOp,
  output logic [2:0]  NPCOp,
  output logic        EXTsign,
  output logic [2:0]  state,
  output logic        retire,
  output logic [31:0] retire_cnt
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] retire_cnt_q, retire_cnt_d;

  logic [5:0] op, funct;
  logic is_add, is_sub, is_jr, is_ori, is_lui, is_lw, is_sw, is_beq, is_jal, is_nop;
  logic unused_ir_bits;

  assign op    = ir_q[31:26];
  assign funct = ir_q[5:0];
  // Register/immediate fields are consumed by the datapath, not by the controller.
  assign unused_ir_bits = ^ir_q[25:6];

  // Instruction class decode from the latched instruction register.
  always_comb begin
    is_add = (op == 6'b000000) && (funct == 6'b100000);
    is_sub = (op == 6'b000000) && (funct == 6'b100010);
    is_jr  = (op == 6'b000000) && (funct == 6'b001000);
    is_ori = (op == 6'b001101);
    is_lui = (op == 6'b001111);
    is_lw  = (op == 6'b100011);
    is_sw  = (op == 6'b101011);
    is_beq = (op == 6'b000100);
    is_jal = (op == 6'b000011);
    is_nop = !(is_add || is_sub || is_jr || is_ori || is_lui ||
               is_lw || is_sw || is_beq || is_jal);
  end

  // Next-state sequencing and per-state control outputs.
  always_comb begin
    state_d  = S_FETCH;
    ir_d     = ir_q;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    RegWrite = 1'b0;
    MemWrite = 1'b0;
    MemtoReg = 3'd0;
    ALUOp    = 3'd0;
    ALUSrc   = 3'd0;
    RegDst   = 3'd0;
    DMOp     = 3'd0;
    NPCOp    = 3'd0;
    EXTsign  = 1'b0;

    // ALU controls stay stable from EXEC to the end of the instruction.
    if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      if (is_sub || is_beq)      ALUOp = 3'd1;
      else if (is_ori)           ALUOp = 3'd2;
      else if (is_lui)           ALUOp = 3'd3;
      if (is_ori || is_lui || is_lw || is_sw) ALUSrc = 3'd1;
      EXTsign = is_lw || is_sw || is_beq;
    end

    case (state_q)
      S_FETCH: begin
        IRWrite = 1'b1;
        ir_d    = instr;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (is_nop) begin
          PCWrite = 1'b1;
          state_d = S_FETCH;
        end else if (is_jal) begin
          state_d = S_WB;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_beq || is_jr) begin
          PCWrite = 1'b1;
          NPCOp   = is_beq ? 3'd1 : 3'd3;
          state_d = S_FETCH;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (is_sw) begin
          MemWrite = 1'b1;
          PCWrite  = 1'b1;
          state_d  = S_FETCH;
        end else begin
          state_d  = S_WB;
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
        state_d  = S_FETCH;
        if (is_add || is_sub) RegDst = 3'd1;
        else if (is_jal)      RegDst = 3'd2;
        if (is_lw)            MemtoReg = 3'd1;
        else if (is_jal)      MemtoReg = 3'd2;
        if (is_jal)           NPCOp = 3'd2;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset suppresses every side effect of the in-flight instruction.
    if (reset) begin
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
    end
  end

  assign retire = PCWrite;
  assign state  = state_q;

  // Retired-instruction counter, wraps silently.
  always_comb begin
    retire_cnt_d = retire ? retire_cnt_q + 32'd1 : retire_cnt_q;
  end

  assign retire_cnt = retire_cnt_q;

  // State, instruction register and counter flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_FETCH;
      ir_q         <= 32'd0;
      retire_cnt_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      ir_q         <= ir_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL have ports: clk in 1, rising-edge clock; reset in 1, synchronous, active-high.
REQ-002 SHALL have instr in 32: instruction word from instruction memory, sampled only in FETCH.
REQ-003 SHALL have outputs: IRWrite 1, PCWrite 1, RegWrite 1, MemWrite 1; MemtoReg, ALUOp, ALUSrc, RegDst, DMOp and NPCOp 3 each; EXTsign 1.
REQ-004 SHALL have outputs: state 3 (current state code); retire 1 (instruction-complete pulse); retire_cnt 32 (retired-instruction count).

Function
REQ-005 SHALL implement FSM states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; codes 5-7 are illegal and SHALL return to FETCH on the next edge.
REQ-006 SHALL latch instr into internal ir at the end of FETCH; all decoding uses ir, never live instr.
REQ-007 SHALL decode: R-type op 000000 with funct 100000 add, 100010 sub, 001000 jr; op 001101 ori, 001111 lui, 100011 lw, 101011 sw, 000100 beq, 000011 jal; every other encoding, including all-zero, is NOP.
REQ-008 SHALL sequence: add/sub/ori/lui F-D-E-W (4 cycles); lw F-D-E-M-W (5); sw F-D-E-M (4); beq and jr F-D-E (3); jal F-D-W (3); NOP F-D (2).
REQ-009 SHALL assert IRWrite only in FETCH.
REQ-010 SHALL assert PCWrite and retire for exactly one cycle, in the last state of each sequence per REQ-008.
REQ-011 SHALL drive NPCOp only while PCWrite=1: 0 pc+4; 1 beq (branch taken when datapath equal=1); 2 jal; 3 jr. Otherwise NPCOp=0.
REQ-012 SHALL assert RegWrite only in WB.
REQ-013 In WB, RegDst SHALL be 1 (rd) for add/sub, 0 (rt) for ori/lui/lw, 2 ($31) for jal.
REQ-014 In WB, MemtoReg SHALL be 0 (ALU) for add/sub/ori/lui, 1 (DM) for lw, 2 (pc+4) for jal.
REQ-015 SHALL assert MemWrite only in MEM of sw; DMOp SHALL be 0 (word) in all states.
REQ-016 SHALL hold ALUOp from EXEC through the end of the sequence: 0 add (add/lw/sw), 1 sub (sub/beq), 2 or (ori), 3 lui.
REQ-017 SHALL hold ALUSrc from EXEC through the end of the sequence: 0 (Grt) for add/sub/beq, 1 (imm32) for ori/lui/lw/sw.
REQ-018 SHALL set EXTsign=1 for lw/sw/beq and 0 otherwise.
REQ-019 Outside their asserting states, all control outputs SHALL be 0.
REQ-020 SHALL increment retire_cnt by 1 on each edge where retire=1, including NOP; it wraps 0xFFFFFFFF -> 0 silently.
REQ-021 SHALL drive all outputs as registered state plus combinational decode only, with no combinational path from instr to any output.

Reset
REQ-022 While reset=1 at an edge: state<=FETCH, ir<=0, retire_cnt<=0.
REQ-023 While reset=1, all write enables (IRWrite, PCWrite, RegWrite, MemWrite) and retire SHALL be forced to 0.
REQ-024 The first cycle after reset deasserts SHALL be FETCH with IRWrite=1.
REQ-025 Reset asserted mid-sequence (e.g. lw in MEM) SHALL abort the instruction: no RegWrite, no retire, no counter update.

Verification
REQ-026 add $3,$1,$2 (0x00221820) after reset -> states 0,1,2,4; WB: RegWrite=1, RegDst=1, MemtoReg=0, ALUOp=0; PCWrite=1 in WB only; retire_cnt=1.
REQ-027 lw $2,4($1) (0x8C220004) -> 5 cycles; ALUSrc=1 and EXTsign=1 in E/M/W; WB: MemtoReg=1, RegDst=0; MemWrite=0 throughout.
REQ-028 sw then beq (0xAC220008, 0x10220003) -> sw: MemWrite=1 for exactly 1 cycle, RegWrite never set; beq: PCWrite=1 with NPCOp=1 and ALUOp=1 in EXEC; total 7 cycles, retire_cnt=2.
REQ-029 jal 0x0C000010 then jr $31 (0x03E00008) -> jal WB: RegDst=2, MemtoReg=2, NPCOp=2; jr EXEC: NPCOp=3, RegWrite=0.
REQ-030 Instruction 0x00000000 and illegal op 0xFC000000 -> each 2 cycles, no RegWrite/MemWrite, PCWrite=1 with NPCOp=0, retire_cnt increments.
REQ-031 reset pulsed during lw MEM; separately, retire_cnt preset near 0xFFFFFFFF -> first: next cycle FETCH, no RegWrite, retire_cnt=0; second: wraps to 0 on the next retire.
